// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register.
// Provides the 2-bit mode type and the four operating-mode encodings
// used by univ_shift_reg and its bench.
package shreg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;  // keep contents
  localparam mode_t MODE_SHR  = 2'b01;  // shift toward bit 0, si_msb enters at top
  localparam mode_t MODE_SHL  = 2'b10;  // shift toward MSB, si_lsb enters at bit 0
  localparam mode_t MODE_LOAD = 2'b11;  // parallel load, restarts the frame

endpackage

// File: rtl/shreg_frame_cnt.sv
// Frame counter for the universal shift register.
// Counts shifts modulo WIDTH and pulses frame_done (registered) for one
// cycle after the shift that completes a WIDTH-bit frame.
// Ports:
//   clock      rising-edge clock
//   rst        asynchronous reset, active-low
//   inc        one shift happens at this edge
//   clr        load at this edge: discard the partial frame (wins over inc)
//   cnt        shifts completed in the current frame
//   frame_done one-cycle pulse after the WIDTH-th shift of a frame
module shreg_frame_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             fd_r;
  logic             fd_next_s;

  // Next counter value and frame pulse; the pulse is never held over.
  always_comb begin
    cnt_next_s = cnt_r;
    fd_next_s  = 1'b0;
    if (clr) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (inc) begin
      if (cnt_r == CNT_LAST) begin
        cnt_next_s = {CNT_W{1'b0}};
        fd_next_s  = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter and pulse registers with asynchronous clear.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
      fd_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      fd_r  <= fd_next_s;
    end
  end

  assign cnt        = cnt_r;
  assign frame_done = fd_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with serial I/O at both ends and a frame counter.
// Build option: define SHREG_ROTATE_EN to let rot=1 recirculate the bit
// falling off the opposite end instead of taking the serial input.
// Without it, rot is accepted but has no effect.
// Ports:
//   clock      rising-edge clock
//   rst        asynchronous reset, active-low
//   en         cycle enable (0 holds everything)
//   mode       00 hold, 01 shift right, 10 shift left, 11 load
//   si_msb     serial in at bit WIDTH-1 (shift right)
//   si_lsb     serial in at bit 0 (shift left)
//   rot        rotate request
//   pin        parallel load data
//   pout       register contents
//   so_lsb     q[0]
//   so_msb     q[WIDTH-1]
//   cnt        shifts completed in current frame
//   frame_done one-cycle pulse after the WIDTH-th shift of a frame
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_msb,
  input  logic             si_lsb,
  input  logic             rot,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             so_lsb,
  output logic             so_msb,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             msb_in_s;
  logic             lsb_in_s;
  logic             inc_s;
  logic             clr_s;
  mode_t            mode_s;

  assign mode_s = mode_t'(mode);

`ifdef SHREG_ROTATE_EN
  // Pick the bits entering each end: serial inputs, or the opposite end when rotating.
  always_comb begin
    msb_in_s = si_msb;
    lsb_in_s = si_lsb;
    if (rot) begin
      msb_in_s = q_r[0];
      lsb_in_s = q_r[WIDTH-1];
    end else begin
      msb_in_s = si_msb;
      lsb_in_s = si_lsb;
    end
  end
`else
  logic rot_unused_s;
  assign rot_unused_s = rot;

  // Serial inputs always feed the shifting ends in this build.
  always_comb begin
    msb_in_s = si_msb;
    lsb_in_s = si_lsb;
  end
`endif

  // Data-path mux and counter controls, gated by the cycle enable.
  always_comb begin
    q_next_s = q_r;
    inc_s    = 1'b0;
    clr_s    = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_HOLD: begin
          q_next_s = q_r;
        end
        MODE_SHR: begin
          q_next_s = {msb_in_s, q_r[WIDTH-1:1]};
          inc_s    = 1'b1;
        end
        MODE_SHL: begin
          q_next_s = {q_r[WIDTH-2:0], lsb_in_s};
          inc_s    = 1'b1;
        end
        MODE_LOAD: begin
          q_next_s = pin;
          clr_s    = 1'b1;
        end
        default: begin
          q_next_s = q_r;
        end
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Shift register with asynchronous clear.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= q_next_s;
    end
  end

  shreg_frame_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clock      (clock),
    .rst        (rst),
    .inc        (inc_s),
    .clr        (clr_s),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  // Outputs are plain register taps.
  assign pout   = q_r;
  assign so_lsb = q_r[0];
  assign so_msb = q_r[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed steps from
// the test plan followed by random steps, all checked against a
// behavioural model kept as an integer value and a shift count.
module tb_univ_shift_reg;

  logic       clock;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       si_msb;
  logic       si_lsb;
  logic       rot;
  logic [7:0] pin;
  logic [7:0] pout;
  logic       so_lsb;
  logic       so_msb;
  logic [2:0] cnt;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int fd_seen  = 0;

  // behavioural model state
  logic [7:0] m_q   = 8'h00;
  int         m_cnt = 0;
  logic       m_fd  = 1'b0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .si_msb     (si_msb),
    .si_lsb     (si_lsb),
    .rot        (rot),
    .pin        (pin),
    .pout       (pout),
    .so_lsb     (so_lsb),
    .so_msb     (so_msb),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ":pout"}, 64'(pout), 64'(m_q));
    check({tag, ":cnt"}, 64'(cnt), 64'(m_cnt));
    check({tag, ":fd"}, 64'(frame_done), 64'(m_fd));
    check({tag, ":so_lsb"}, 64'(so_lsb), 64'(m_q % 2));
    check({tag, ":so_msb"}, 64'(so_msb), 64'(m_q / 128));
  endtask

  // One clock step: drive inputs, advance the model, check just after the edge.
  task automatic apply(input logic e, input logic [1:0] md, input logic sm,
                       input logic sl, input logic r, input logic [7:0] p);
    logic msb_b;
    logic lsb_b;
    en = e; mode = md; si_msb = sm; si_lsb = sl; rot = r; pin = p;
    msb_b = sm;
    lsb_b = sl;
`ifdef SHREG_ROTATE_EN
    if (r) begin
      msb_b = m_q[0];
      lsb_b = m_q[7];
    end
`endif
    m_fd = 1'b0;
    if (e) begin
      if (md == 2'd3) begin
        m_q   = p;
        m_cnt = 0;
      end else if (md == 2'd1 || md == 2'd2) begin
        if (md == 2'd1) m_q = 8'((m_q / 2) + (msb_b ? 128 : 0));
        else            m_q = 8'((m_q * 2) + (lsb_b ? 1 : 0));
        m_cnt = (m_cnt + 1) % 8;
        m_fd  = (m_cnt == 0);
      end
    end
    @(posedge clock);
    #1;
    if (frame_done) fd_seen++;
    check_model("step");
  endtask

  initial begin
    logic [7:0] seq;
    logic [1:0] md;
    rst = 1'b0; en = 1'b0; mode = 2'd0; si_msb = 1'b0; si_lsb = 1'b0;
    rot = 1'b0; pin = 8'h00;
    #12;
    check("reset:pout", 64'(pout), 64'h0);
    check("reset:cnt", 64'(cnt), 64'h0);
    check("reset:fd", 64'(frame_done), 64'h0);
    @(negedge clock);
    rst = 1'b1;

    // load A5 then shift out 8 bits LSB first
    apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5);
    check("load_a5", 64'(pout), 64'hA5);
    seq = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("so_lsb_pre", 64'(so_lsb), 64'(seq[i]));
      apply(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    check("shr8:pout", 64'(pout), 64'h00);
    check("shr8:fd", 64'(frame_done), 64'h1);
    check("shr8:cnt", 64'(cnt), 64'h0);

    // shift left 3 with ones
    for (int i = 0; i < 3; i++) apply(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00);
    check("shl3:pout", 64'(pout), 64'h07);
    check("shl3:cnt", 64'(cnt), 64'h3);
    check("shl3:fd", 64'(frame_done), 64'h0);

    // reach cnt=5, then load discards partial frame
    apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pre_load:cnt", 64'(cnt), 64'h5);
    apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h3C);
    check("load_3c:pout", 64'(pout), 64'h3C);
    check("load_3c:cnt", 64'(cnt), 64'h0);
    check("load_3c:fd", 64'(frame_done), 64'h0);
    fd_seen = 0;
    for (int i = 0; i < 8; i++) apply(1'b1, 2'(1 + (i % 2)), 1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("one_frame_done", 64'(fd_seen), 64'h1);

    // enable low holds everything
    apply(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) apply(1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("en0:cnt", 64'(cnt), 64'h1);

    // reach 5A with cnt=4, then drop reset between edges
    apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h05);
    apply(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    check("mid:pout", 64'(pout), 64'h5A);
    check("mid:cnt", 64'(cnt), 64'h4);
    @(negedge clock);
    #2;
    rst = 1'b0;
    #1;
    m_q = 8'h00; m_cnt = 0; m_fd = 1'b0;
    check("async_rst:pout", 64'(pout), 64'h0);
    check("async_rst:cnt", 64'(cnt), 64'h0);
    check("async_rst:fd", 64'(frame_done), 64'h0);
    @(negedge clock);
    rst = 1'b1;
    apply(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("after_rst:cnt", 64'(cnt), 64'h1);

    // rotate requests (expected values depend on build)
    apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h81);
    apply(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef SHREG_ROTATE_EN
    check("rot_shl", 64'(pout), 64'h03);
`else
    check("rot_shl", 64'(pout), 64'h02);
`endif
    apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h81);
    apply(1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef SHREG_ROTATE_EN
    check("rot_shr", 64'(pout), 64'hC0);
`else
    check("rot_shr", 64'(pout), 64'h40);
`endif

    // random steps against the model
    for (int i = 0; i < 400; i++) begin
      md = 2'($urandom_range(0, 3));
      if (md == 2'd3 && $urandom_range(0, 2) != 0) md = 2'd1;
      apply(1'($urandom_range(0, 7) != 0), md, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
